bus_arbiter: RTL and testbench

//   Round-robin arbiter and sequencer for a shared WIDTH-bit datapath built from
//   mux arrays. It grants one of NUM_REQ requesters, drives the mux select, and

---
 rtl/bus_arbiter_if.sv | 28 ++
 rtl/bus_arbiter.sv | 132 +++++++++++++
 tb/tb_bus_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// Request/grant/data bundle between the requesters and the bus arbiter.
// slave: arbiter side (takes req/data_in, drives grant/sel/data_out/flags).
// master: requester side (drives req/data_in, observes grant and bus).
interface bus_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16
);
    localparam int SW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] data_in;
    logic [NUM_REQ-1:0]       grant;
    logic [SW-1:0]            sel;
    logic [WIDTH-1:0]         data_out;
    logic                     data_valid;
    logic                     busy;
    logic                     timeout;

    modport slave (
        input  req, data_in,
        output grant, sel, data_out, data_valid, busy, timeout
    );

    modport master (
        output req, data_in,
        input  grant, sel, data_out, data_valid, busy, timeout
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter/sequencer for a shared mux-array datapath.
// Ports: clk, reset (sync, active-high), bus (bus_arbiter_if.slave):
//   req/data_in in; grant (one-hot), sel, data_out, data_valid, busy,
//   timeout out. Optional macro ARB_TIMEOUT_EN enables the MAX_HOLD
//   forced revoke; without it grants are held indefinitely.
module bus_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int WIDTH    = 16,
    parameter int MAX_HOLD = 15
) (
    input  logic         clk,
    input  logic         reset,
    bus_arbiter_if.slave bus
);
    localparam int SW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t             state, state_nx;
    logic [NUM_REQ-1:0] grant_q, grant_nx;
    logic [SW-1:0]      sel_q, sel_nx;
    logic [SW-1:0]      last_q, last_nx;
    logic [SW-1:0]      win_idx;
    logic [SW-1:0]      cand;
    logic               win_found;
    logic [WIDTH-1:0]   dout_q;
    logic               valid_q;
    logic               revoke;
    logic               timeout_q;

    // First requester after last_owner, wrapping; last_owner itself is
    // checked last so a re-raising owner gets lowest priority.
    always_comb begin
        win_idx   = last_q;
        win_found = 1'b0;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = SW'((int'(last_q) + i) % NUM_REQ);
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);

    logic [HW-1:0] hold_cnt;

    assign revoke = (state == GRANT) && bus.req[sel_q] &&
                    (hold_cnt == HW'(MAX_HOLD - 1));

    // Restarts on any grant change, so a handover gets a full window.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt <= '0;
        end else if (state_nx != GRANT || grant_nx != grant_q) begin
            hold_cnt <= '0;
        end else if (hold_cnt != HW'(MAX_HOLD)) begin
            hold_cnt <= hold_cnt + HW'(1);
        end
    end
`else
    assign revoke = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        grant_nx = grant_q;
        sel_nx   = sel_q;
        last_nx  = last_q;
        unique case (state)
            IDLE: begin
                if (win_found) begin
                    grant_nx = NUM_REQ'(1) << win_idx;
                    sel_nx   = win_idx;
                    last_nx  = win_idx;
                    state_nx = GRANT;
                end
            end
            GRANT: begin
                if (!bus.req[sel_q]) begin
                    // Direct handover avoids an idle bubble.
                    if (win_found) begin
                        grant_nx = NUM_REQ'(1) << win_idx;
                        sel_nx   = win_idx;
                        last_nx  = win_idx;
                    end else begin
                        grant_nx = '0;
                        state_nx = IDLE;
                    end
                end else if (revoke) begin
                    grant_nx = '0;
                    state_nx = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            grant_q   <= '0;
            sel_q     <= '0;
            last_q    <= SW'(NUM_REQ - 1);
            dout_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nx;
            grant_q   <= grant_nx;
            sel_q     <= sel_nx;
            last_q    <= last_nx;
            valid_q   <= |grant_q;
            timeout_q <= revoke;
            if (state == GRANT) begin
                dout_q <= bus.data_in[int'(sel_q)*WIDTH +: WIDTH];
            end
        end
    end

    assign bus.grant      = grant_q;
    assign bus.sel        = sel_q;
    assign bus.data_out   = dout_q;
    assign bus.data_valid = valid_q;
    assign bus.busy       = |grant_q;
    assign bus.timeout    = timeout_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: expected bus state is queued with each stimulus
// step and popped/compared one edge later.
module tb_bus_arbiter;
    localparam int NR = 4;
    localparam int W  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bus_arbiter_if #(.NUM_REQ(NR), .WIDTH(W)) bus ();

    bus_arbiter #(.NUM_REQ(NR), .WIDTH(W), .MAX_HOLD(4)) dut (
        .clk  (clk),
        .reset(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [3:0]  grant;
        logic [1:0]  sel;
        logic [15:0] dout;
        logic        valid;
        logic        to;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] eg,
                        input logic [1:0] es, input logic [15:0] ed,
                        input logic ev, input logic et, input string tag);
        exp_t e;
        bus.req = r;
        e.tag = tag; e.grant = eg; e.sel = es;
        e.dout = ed; e.valid = ev; e.to = et;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".grant"}, 32'(bus.grant), 32'(e.grant));
            chk({e.tag, ".sel"}, 32'(bus.sel), 32'(e.sel));
            chk({e.tag, ".dout"}, 32'(bus.data_out), 32'(e.dout));
            chk({e.tag, ".valid"}, 32'(bus.data_valid), 32'(e.valid));
            chk({e.tag, ".busy"}, 32'(bus.busy), 32'(e.grant != 4'b0));
            chk({e.tag, ".to"}, 32'(bus.timeout), 32'(e.to));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req     = '0;
        bus.data_in = {16'h3333, 16'h2222, 16'h1111, 16'hBEEF};
        @(posedge clk);
        #1;
        // reset state
        rst = 1'b1;
        step(4'b0000, 4'b0000, 0, 16'h0000, 0, 0, "rst0");
        step(4'b0000, 4'b0000, 0, 16'h0000, 0, 0, "rst1");
        rst = 1'b0;

        // single requester, data latency
        step(4'b0001, 4'b0001, 0, 16'h0000, 0, 0, "t1g");
        step(4'b0001, 4'b0001, 0, 16'hBEEF, 1, 0, "t1d");
        step(4'b0000, 4'b0000, 0, 16'hBEEF, 1, 0, "t1r");
        step(4'b0000, 4'b0000, 0, 16'hBEEF, 0, 0, "t1v");
        // idle holds last word
        for (int i = 0; i < 10; i++)
            step(4'b0000, 4'b0000, 0, 16'hBEEF, 0, 0, "t6idle");

        // round robin rotation without bubbles
        rst = 1'b1;
        step(4'b0000, 4'b0000, 0, 16'h0000, 0, 0, "t2rst");
        rst = 1'b0;
        step(4'b1111, 4'b0001, 0, 16'h0000, 0, 0, "t2a");
        step(4'b1111, 4'b0001, 0, 16'hBEEF, 1, 0, "t2b");
        step(4'b1110, 4'b0010, 1, 16'hBEEF, 1, 0, "t2c");
        step(4'b1111, 4'b0010, 1, 16'h1111, 1, 0, "t2d");
        step(4'b1101, 4'b0100, 2, 16'h1111, 1, 0, "t2e");
        step(4'b1101, 4'b0100, 2, 16'h2222, 1, 0, "t2f");
        step(4'b1001, 4'b1000, 3, 16'h2222, 1, 0, "t2g");
        step(4'b1001, 4'b1000, 3, 16'h3333, 1, 0, "t2h");
        step(4'b0001, 4'b0001, 0, 16'h3333, 1, 0, "t2i");
        step(4'b0001, 4'b0001, 0, 16'hBEEF, 1, 0, "t2j");
        step(4'b0000, 4'b0000, 0, 16'hBEEF, 1, 0, "t2k");
        step(4'b0000, 4'b0000, 0, 16'hBEEF, 0, 0, "t2l");

        // other requests ignored while owned
        rst = 1'b1;
        step(4'b0000, 4'b0000, 0, 16'h0000, 0, 0, "t3rst");
        rst = 1'b0;
        step(4'b0100, 4'b0100, 2, 16'h0000, 0, 0, "t3a");
        step(4'b1100, 4'b0100, 2, 16'h2222, 1, 0, "t3b");
        step(4'b1100, 4'b0100, 2, 16'h2222, 1, 0, "t3c");
        step(4'b1000, 4'b1000, 3, 16'h2222, 1, 0, "t3d");
        step(4'b1000, 4'b1000, 3, 16'h3333, 1, 0, "t3e");

        // reset mid-grant, last_owner back to NUM_REQ-1
        step(4'b0100, 4'b0100, 2, 16'h3333, 1, 0, "t5a");
        rst = 1'b1;
        step(4'b0100, 4'b0000, 0, 16'h0000, 0, 0, "t5rst");
        rst = 1'b0;
        step(4'b1001, 4'b0001, 0, 16'h0000, 0, 0, "t5b");
        step(4'b1001, 4'b0001, 0, 16'hBEEF, 1, 0, "t5c");
        step(4'b0000, 4'b0000, 0, 16'hBEEF, 1, 0, "t5d");
        step(4'b0000, 4'b0000, 0, 16'hBEEF, 0, 0, "t5e");

        // hold limit (MAX_HOLD=4)
        step(4'b0010, 4'b0010, 1, 16'hBEEF, 0, 0, "t4a");
        step(4'b0010, 4'b0010, 1, 16'h1111, 1, 0, "t4b");
        step(4'b0010, 4'b0010, 1, 16'h1111, 1, 0, "t4c");
        step(4'b0010, 4'b0010, 1, 16'h1111, 1, 0, "t4d");
`ifdef ARB_TIMEOUT_EN
        step(4'b0010, 4'b0000, 1, 16'h1111, 1, 1, "t4to");
        step(4'b0010, 4'b0010, 1, 16'h1111, 0, 0, "t4re");
        step(4'b0010, 4'b0010, 1, 16'h1111, 1, 0, "t4f");
`else
        step(4'b0010, 4'b0010, 1, 16'h1111, 1, 0, "t4e");
        step(4'b0010, 4'b0010, 1, 16'h1111, 1, 0, "t4f");
        step(4'b0010, 4'b0010, 1, 16'h1111, 1, 0, "t4g");
`endif
        step(4'b0000, 4'b0000, 1, 16'h1111, 1, 0, "t4r");
        step(4'b0000, 4'b0000, 1, 16'h1111, 0, 0, "t4v");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
